// File: rtl/stack_ctrl_if.sv
// Control/status bundle between the stack-processor control FSM and its datapath.
// The slave side is the controller; the master side drives instruction, start and flags.
interface stack_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [15:0]      IRw;
    logic             zero;
    logic             overflow;
    logic             IRWrite;
    logic             PCWrite;
    logic             PCSrc;
    logic             PushSel;
    logic             popAmt;
    logic             ESAct;
    logic [1:0]       ESop;
    logic [1:0]       ALUOp;
    logic             ALUSrcB;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output start, IRw, zero, overflow,
        input  IRWrite, PCWrite, PCSrc, PushSel, popAmt, ESAct,
               ESop, ALUOp, ALUSrcB, halted, instr_count
    );

    modport slave (
        input  start, IRw, zero, overflow,
        output IRWrite, PCWrite, PCSrc, PushSel, popAmt, ESAct,
               ESop, ALUOp, ALUSrcB, halted, instr_count
    );
endinterface

// File: rtl/stack_ctrl.sv
// Multicycle control FSM for the stack processor: fetch, decode, execute, write-back, branch.
// Optional macro STACK_CTRL_TRAP_OVF_EN: ADD/SUB/ADDI overflow in EXEC traps to HALT.
module stack_ctrl #(
    parameter int CNT_W = 16
) (
    input logic          clk,
    input logic          reset,
    stack_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_BRANCH, S_HALT
    } state_t;

    localparam logic [3:0] OP_PUSHI = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_DUP   = 4'h6;
    localparam logic [3:0] OP_POP   = 4'h7;
    localparam logic [3:0] OP_BEQ   = 4'h8;
    localparam logic [3:0] OP_JMP   = 4'h9;

    localparam logic [1:0] ES_PUSH    = 2'b00;
    localparam logic [1:0] ES_POP     = 2'b01;
    localparam logic [1:0] ES_DUP     = 2'b10;
    localparam logic [1:0] ES_REPLACE = 2'b11;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_instr_count;
    logic [3:0]       w_opcode;
    logic             w_trap;

    assign w_opcode = bus.IRw[15:12];

`ifdef STACK_CTRL_TRAP_OVF_EN
    assign w_trap = bus.overflow &&
                    (w_opcode == OP_ADD || w_opcode == OP_SUB || w_opcode == OP_ADDI);
    logic w_unused_ir;
    assign w_unused_ir = &{1'b0, bus.IRw[11:0]};
`else
    assign w_trap = 1'b0;
    logic w_unused_ir;
    assign w_unused_ir = &{1'b0, bus.IRw[11:0], bus.overflow};
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves a variable unassigned (no latch).
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_state_next = S_FETCH;
            S_FETCH:  w_state_next = S_DECODE;
            S_DECODE: begin
                case (w_opcode)
                    OP_PUSHI, OP_DUP, OP_POP:                    w_state_next = S_WB;
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI:      w_state_next = S_EXEC;
                    OP_BEQ, OP_JMP:                              w_state_next = S_BRANCH;
                    default:                                     w_state_next = S_HALT;
                endcase
            end
            S_EXEC:   w_state_next = w_trap ? S_HALT : S_WB;
            S_WB:     w_state_next = S_FETCH;
            S_BRANCH: w_state_next = S_FETCH;
            S_HALT:   w_state_next = S_HALT;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // WB and BRANCH always return to FETCH, so leaving them retires an instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_instr_count <= '0;
        else if (r_state == S_WB || r_state == S_BRANCH)
            r_instr_count <= r_instr_count + 1'b1;
    end

    assign bus.instr_count = r_instr_count;

    always_comb begin
        bus.IRWrite = 1'b0;
        bus.PCWrite = 1'b0;
        bus.PCSrc   = 1'b0;
        bus.PushSel = 1'b0;
        bus.popAmt  = 1'b0;
        bus.ESAct   = 1'b0;
        bus.ESop    = ES_PUSH;
        bus.ALUOp   = 2'b00;
        bus.ALUSrcB = 1'b0;
        bus.halted  = 1'b0;
        case (r_state)
            S_FETCH: begin
                bus.IRWrite = 1'b1;
                bus.PCWrite = 1'b1;
            end
            S_EXEC: begin
                if (w_opcode == OP_ADDI) bus.ALUSrcB = 1'b1;
                else                     bus.ALUOp   = 2'(w_opcode - 4'd1);
            end
            S_WB: begin
                bus.ESAct = 1'b1;
                case (w_opcode)
                    OP_PUSHI: begin
                        bus.ESop    = ES_PUSH;
                        bus.PushSel = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        bus.ESop   = ES_REPLACE;
                        bus.popAmt = 1'b1;
                    end
                    OP_ADDI: bus.ESop = ES_REPLACE;
                    OP_DUP:  bus.ESop = ES_DUP;
                    OP_POP:  bus.ESop = ES_POP;
                    default: bus.ESAct = 1'b0;
                endcase
            end
            S_BRANCH: begin
                if (w_opcode == OP_BEQ) begin
                    // Compare-and-consume: the subtraction drives zero, both operands are popped.
                    bus.ALUOp   = 2'b01;
                    bus.ESAct   = 1'b1;
                    bus.ESop    = ES_POP;
                    bus.popAmt  = 1'b1;
                    bus.PCWrite = bus.zero;
                    bus.PCSrc   = 1'b1;
                end else if (w_opcode == OP_JMP) begin
                    bus.PCWrite = 1'b1;
                    bus.PCSrc   = 1'b1;
                end
            end
            S_HALT:  bus.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Multicycle control FSM for the stack processor datapath. It sits directly upstream of the execution-stack subsystem. It decodes the opcode field of the instruction register and drives the subsystem's stack controls (popAmt, ESAct, ESop), ALU controls (ALUOp, ALUSrcB) and push-value select. It also sequences instruction fetch and PC update, and consumes the subsystem's zero/overflow flags for branches and traps.

## Interface
Parameters:
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  leave IDLE and begin fetching
- IRw  in  16  instruction register contents; opcode = IRw[15:12]
- zero  in  1  ALU zero flag from execution subsystem
- overflow  in  1  ALU overflow flag from execution subsystem
- IRWrite  out  1  load instruction register
- PCWrite  out  1  load PC
- PCSrc  out  1  0 = PC+1, 1 = PC + sign-extended offset
- PushSel  out  1  0 = push ALUOut, 1 = push sign-extended immediate
- popAmt  out  1  0 = one entry, 1 = two entries
- ESAct  out  1  execution stack performs ESop this cycle
- ESop  out  2  00 push, 01 pop, 10 dup, 11 replace (pop popAmt-selected count, then push)
- ALUOp  out  2  00 add, 01 sub, 10 and, 11 or
- ALUSrcB  out  1  0 = B, 1 = sign-extended immediate
- halted  out  1  FSM in HALT
- instr_count  out  CNT_W  retired instructions

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, BRANCH, HALT.
- Outputs are Moore: decoded from state and, from DECODE onward, the opcode in IRw[15:12].
- All outputs are 0 in IDLE and HALT except halted (1 in HALT).
- IDLE: wait for start = 1, then go to FETCH.
- FETCH: IRWrite = 1, PCWrite = 1, PCSrc = 0; next state DECODE.
- DECODE: A/B registers capture stack top. Next state by opcode:
  - 0x0 PUSHI → WB
  - 0x1 ADD, 0x2 SUB, 0x3 AND, 0x4 OR, 0x5 ADDI → EXEC
  - 0x6 DUP, 0x7 POP → WB
  - 0x8 BEQ, 0x9 JMP → BRANCH
  - 0xA–0xF → HALT (illegal opcode)
- EXEC: ALUOp = opcode − 1 for 0x1–0x4, 00 for ADDI. ALUSrcB = 1 only for ADDI. ALUOut latches at the clock edge. Next state WB.
- WB: ESAct = 1, next state FETCH. ESop/popAmt/PushSel by opcode:
  - PUSHI: push, PushSel = 1
  - binary ALU ops: replace, popAmt = 1
  - ADDI: replace, popAmt = 0
  - DUP: dup
  - POP: pop, popAmt = 0
- BRANCH:
  - BEQ: ALUOp = 01, ALUSrcB = 0, ESAct = 1, ESop = 01, popAmt = 1. PCWrite = zero, PCSrc = 1.
  - JMP: PCWrite = 1, PCSrc = 1, no stack activity.
  - Next state FETCH.
- instr_count increments by 1 on every transition into FETCH from WB or BRANCH. It wraps at 2^CNT_W − 1 → 0.
- HALT is absorbing. Only reset exits it; start is ignored there.

## Timing
- Reset (reset = 0), asynchronous: state = IDLE, instr_count = 0, all outputs 0, halted = 0.
- A reset asserted mid-instruction aborts it immediately. No partial stack write occurs after assertion.
- Cycles per instruction (FETCH through last state):
  - PUSHI, DUP, POP, BEQ, JMP: 3
  - ALU ops: 4
- start is sampled only in IDLE. start held high has no effect after leaving IDLE.
- zero is sampled combinationally in BRANCH and is valid because A/B were registered in DECODE.
- A stack push on a full stack and a pop on an empty stack are handled in the stack, not here.

## Configuration
- STACK_CTRL_TRAP_OVF_EN defined: in EXEC, if overflow = 1 for ADD, SUB or ADDI, the next state is HALT. WB is skipped: no push, and instr_count does not increment.
- STACK_CTRL_TRAP_OVF_EN undefined: overflow is ignored and the wrapped result is pushed.

## Test plan
- Reset and start: reset = 0 for 2 cycles, release, hold start = 0 for 5 cycles → state stays IDLE, all outputs 0. Pulse start → IRWrite = PCWrite = 1 on the next cycle.
- PUSHI 0x0050 then ADD:
  - PUSHI WB cycle: ESAct = 1, ESop = 00, PushSel = 1.
  - ADD EXEC cycle: ALUOp = 00, ALUSrcB = 0.
  - ADD WB cycle: ESop = 11, popAmt = 1.
  - instr_count = 2 after 7 cycles.
- BEQ:
  - zero = 1: BRANCH asserts PCWrite = 1, PCSrc = 1, ESop = 01, popAmt = 1.
  - Repeat with zero = 0: PCWrite = 0, stack still pops 2.
- Illegal opcode 0xC → HALT after DECODE, halted = 1, remains halted for 10 cycles with start = 1.
- Overflow on ADD (0x7FFF + 0x0001):
  - Macro defined: HALT with no WB, instr_count unchanged.
  - Macro undefined: WB replace occurs, instr_count increments.
- Reset mid-EXEC of SUB → IDLE next sample, ESAct never asserted, instr_count = 0.
